// File: rtl/card_mem_pkg.sv
// Shared constants and state encoding for the card list memory.
// Op codes, list ids, the NULL node marker and the controller state enum.
package card_mem_pkg;

  localparam int unsigned NUM_CARDS = 52;
  localparam int unsigned NODE_AW   = 6;
  localparam int unsigned NUM_NODES = 1 << NODE_AW;

  localparam logic [NODE_AW-1:0] NULL_NODE = '1;
  localparam logic [NODE_AW-1:0] CARD_MAX  = NODE_AW'(NUM_CARDS);
  localparam logic [NODE_AW-1:0] LAST_NODE = NODE_AW'(NUM_CARDS - 1);

  localparam logic [1:0] OP_PUSH   = 2'd0;
  localparam logic [1:0] OP_REMOVE = 2'd1;
  localparam logic [1:0] OP_INIT   = 2'd2;
  localparam logic [1:0] OP_COUNT  = 2'd3;

  localparam logic [1:0] LIST_DECK   = 2'd0;
  localparam logic [1:0] LIST_PLAYER = 2'd1;
  localparam logic [1:0] LIST_COM    = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StPush,
    StSeek,
    StUnlink,
    StDone
  } state_t;

endpackage

// File: rtl/card_list_memory_node_array.sv
// Node storage: card value and next pointer per node.
// Two combinational read ports, independent card and next write ports.
module card_node_array
  import card_mem_pkg::*;
(
  input  logic               clock,
  input  logic [NODE_AW-1:0] i_rd_addr_a,
  output logic [NODE_AW-1:0] o_card_a,
  output logic [NODE_AW-1:0] o_next_a,
  input  logic [NODE_AW-1:0] i_rd_addr_b,
  output logic [NODE_AW-1:0] o_next_b,
  input  logic               i_card_we,
  input  logic [NODE_AW-1:0] i_card_waddr,
  input  logic [NODE_AW-1:0] i_card_wdata,
  input  logic               i_next_we,
  input  logic [NODE_AW-1:0] i_next_waddr,
  input  logic [NODE_AW-1:0] i_next_wdata
);

  logic [NODE_AW-1:0] r_card [NUM_NODES];
  logic [NODE_AW-1:0] r_next [NUM_NODES];

  always_ff @(posedge clock) begin
    if (i_card_we) r_card[i_card_waddr] <= i_card_wdata;
    if (i_next_we) r_next[i_next_waddr] <= i_next_wdata;
  end

  assign o_card_a = r_card[i_rd_addr_a];
  assign o_next_a = r_next[i_rd_addr_a];
  assign o_next_b = r_next[i_rd_addr_b];

endmodule

// File: rtl/card_list_memory.sv
// Linked-list card storage serving push / remove-at / rebuild / count commands.
// Three lists (deck, player, com) share one node pool with a free list.
module card_list_memory
  import card_mem_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic [1:0]  select_op,
  input  logic [9:0]  arg1,
  input  logic [9:0]  arg2,
  output logic        finished_op,
  output logic [15:0] out1,
  output logic        busy,
  output logic        error
);

  state_t             r_state, w_state_next;
  logic [NODE_AW-1:0] r_head [3];
  logic [NODE_AW-1:0] r_count [3];
  logic [NODE_AW-1:0] r_free_head, r_cur, r_prev, r_steps, r_i, r_card, r_link_next;
  logic [1:0]         r_id;
  logic               r_auto, r_err, r_link;
  logic [15:0]        r_out1;

  logic [NODE_AW-1:0] w_rd_a, w_card_a, w_next_a, w_next_b;
  logic               w_card_we, w_next_we;
  logic [NODE_AW-1:0] w_card_waddr, w_card_wdata, w_next_waddr, w_next_wdata;
  logic [1:0]         w_lid;
  logic               w_id_bad, w_card_bad, w_cmd_err;
  logic               w_unused;

  assign w_unused   = ^{arg1[9:2], arg2[9:6]};
  assign w_id_bad   = (arg1[1:0] == 2'd3);
  assign w_lid      = w_id_bad ? LIST_DECK : arg1[1:0];
  assign w_card_bad = (arg2[5:0] == '0) || (arg2[5:0] > CARD_MAX);

  always_comb begin
    unique case (select_op)
      OP_PUSH:   w_cmd_err = w_id_bad || (r_free_head == NULL_NODE) || w_card_bad;
      OP_REMOVE: w_cmd_err = w_id_bad || (r_count[w_lid] == '0);
      OP_INIT:   w_cmd_err = 1'b0;
      default:   w_cmd_err = w_id_bad;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_a       = r_cur;
    w_card_we    = 1'b0;
    w_card_waddr = r_i;
    w_card_wdata = r_i + 1'b1;
    w_next_we    = 1'b0;
    w_next_waddr = r_i;
    w_next_wdata = (r_i == LAST_NODE) ? NULL_NODE : r_i + 1'b1;
    unique case (r_state)
      StIdle: begin
        if (enable) begin
          if (w_cmd_err) w_state_next = StDone;
          else begin
            unique case (select_op)
              OP_PUSH:   w_state_next = StPush;
              OP_REMOVE: w_state_next = (arg2[5:0] == '0) ? StUnlink : StSeek;
              OP_INIT:   w_state_next = StInit;
              default:   w_state_next = StDone;
            endcase
          end
        end
      end
      StInit: begin
        w_card_we = 1'b1;
        w_next_we = 1'b1;
        if (r_i == LAST_NODE) w_state_next = StDone;
      end
      StPush: begin
        w_card_we    = 1'b1;
        w_card_waddr = r_free_head;
        w_card_wdata = r_card;
        w_next_we    = 1'b1;
        w_next_waddr = r_free_head;
        w_next_wdata = r_head[r_id];
        w_state_next = StDone;
      end
      StSeek: begin
        if (r_steps == NODE_AW'(1)) w_state_next = StUnlink;
      end
      StUnlink: begin
        w_next_we    = (r_prev != NULL_NODE);
        w_next_waddr = r_prev;
        w_next_wdata = w_next_a;
        w_state_next = StDone;
      end
      default: begin
        // The freed node's link to the old free list is written here, since
        // UNLINK already uses the next-write port for the predecessor.
        w_next_we    = r_link;
        w_next_waddr = r_cur;
        w_next_wdata = r_link_next;
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= StInit;
      r_i         <= '0;
      r_auto      <= 1'b1;
      r_err       <= 1'b0;
      r_link      <= 1'b0;
      r_out1      <= '0;
      r_free_head <= NULL_NODE;
      r_cur       <= NULL_NODE;
      r_prev      <= NULL_NODE;
      r_link_next <= NULL_NODE;
      r_steps     <= '0;
      r_card      <= '0;
      r_id        <= LIST_DECK;
      for (int k = 0; k < 3; k++) begin
        r_head[k]  <= NULL_NODE;
        r_count[k] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (enable) begin
            r_id   <= w_lid;
            r_card <= arg2[5:0];
            r_err  <= w_cmd_err;
            r_link <= 1'b0;
            if (w_cmd_err) r_out1 <= 16'hFFFF;
            else if (select_op == OP_REMOVE) begin
              r_cur   <= r_head[w_lid];
              r_prev  <= NULL_NODE;
              r_steps <= arg2[5:0];
            end else if (select_op == OP_INIT) r_i <= '0;
            else if (select_op == OP_COUNT) r_out1 <= {10'd0, r_count[w_lid]};
          end
        end
        StInit: begin
          r_i <= r_i + 1'b1;
          if (r_i == LAST_NODE) begin
            r_head[0]   <= '0;
            r_count[0]  <= CARD_MAX;
            r_head[1]   <= NULL_NODE;
            r_count[1]  <= '0;
            r_head[2]   <= NULL_NODE;
            r_count[2]  <= '0;
            r_free_head <= NULL_NODE;
          end
        end
        StPush: begin
          r_free_head   <= w_next_b;
          r_head[r_id]  <= r_free_head;
          r_count[r_id] <= r_count[r_id] + 1'b1;
        end
        StSeek: begin
          if (w_next_a == NULL_NODE) begin
            r_cur  <= r_head[r_id];
            r_prev <= NULL_NODE;
          end else begin
            r_cur  <= w_next_a;
            r_prev <= r_cur;
          end
          r_steps <= r_steps - 1'b1;
        end
        StUnlink: begin
          r_out1 <= {10'd0, w_card_a};
          if (r_prev == NULL_NODE) r_head[r_id] <= w_next_a;
          r_link_next   <= r_free_head;
          r_free_head   <= r_cur;
          r_link        <= 1'b1;
          r_count[r_id] <= r_count[r_id] - 1'b1;
        end
        default: begin
          r_link <= 1'b0;
          r_auto <= 1'b0;
        end
      endcase
    end
  end

  card_node_array u_nodes (
    .clock        (clock),
    .i_rd_addr_a  (w_rd_a),
    .o_card_a     (w_card_a),
    .o_next_a     (w_next_a),
    .i_rd_addr_b  (r_free_head),
    .o_next_b     (w_next_b),
    .i_card_we    (w_card_we),
    .i_card_waddr (w_card_waddr),
    .i_card_wdata (w_card_wdata),
    .i_next_we    (w_next_we),
    .i_next_waddr (w_next_waddr),
    .i_next_wdata (w_next_wdata)
  );

  assign busy        = (r_state != StIdle);
  assign finished_op = (r_state == StDone) && !r_auto;
  assign error       = (r_state == StDone) && !r_auto && r_err;
  assign out1        = r_out1;

endmodule

// File: tb/tb_card_list_memory.sv
// Self-checking bench for card_list_memory: directed scenarios plus a random
// command mix checked against an array-of-lists reference model.
module tb_card_list_memory;

  logic        clock = 1'b0;
  logic        resetn;
  logic        enable;
  logic [1:0]  select_op;
  logic [9:0]  arg1, arg2;
  logic        finished_op, busy, error;
  logic [15:0] out1;

  int checks = 0;
  int errors = 0;

  int mlist [3][64];
  int msize [3];
  int pool [$];

  card_list_memory dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .select_op   (select_op),
    .arg1        (arg1),
    .arg2        (arg2),
    .finished_op (finished_op),
    .out1        (out1),
    .busy        (busy),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int k = 0; k < 52; k++) mlist[0][k] = k + 1;
    msize[0] = 52;
    msize[1] = 0;
    msize[2] = 0;
  endtask

  // Lists held as plain arrays, index 0 = head; removal position is idx mod size.
  task automatic model_exec(input logic [1:0] op, input logic [9:0] a1, input logic [9:0] a2,
                            output logic [15:0] eout, output logic eerr, output int elat,
                            output logic echk);
    int id, v, total, pos;
    id    = int'(a1[1:0]);
    v     = int'(a2[5:0]);
    total = msize[0] + msize[1] + msize[2];
    eout  = '0;
    eerr  = 1'b0;
    elat  = 1;
    echk  = 1'b1;
    case (op)
      2'd0: begin
        if (id == 3 || total >= 52 || v == 0 || v > 52) begin
          eerr = 1'b1;
          eout = 16'hFFFF;
        end else begin
          for (int k = msize[id]; k > 0; k--) mlist[id][k] = mlist[id][k-1];
          mlist[id][0] = v;
          msize[id]++;
          elat = 2;
          echk = 1'b0;
        end
      end
      2'd1: begin
        if (id == 3 || msize[id] == 0) begin
          eerr = 1'b1;
          eout = 16'hFFFF;
        end else begin
          pos  = v % msize[id];
          eout = 16'(mlist[id][pos]);
          for (int k = pos; k < msize[id] - 1; k++) mlist[id][k] = mlist[id][k+1];
          msize[id]--;
          elat = v + 2;
        end
      end
      2'd2: begin
        model_reset();
        elat = 53;
        echk = 1'b0;
      end
      default: begin
        if (id == 3) begin
          eerr = 1'b1;
          eout = 16'hFFFF;
        end else eout = 16'(msize[id]);
      end
    endcase
  endtask

  // Issues one command, scrambling the command inputs while the DUT is busy.
  task automatic run_op(input logic [1:0] op, input logic [9:0] a1, input logic [9:0] a2,
                        output logic [15:0] o, output logic e, output int lat);
    int guard = 0;
    while (busy && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    select_op = op;
    arg1      = a1;
    arg2      = a2;
    enable    = 1'b1;
    lat       = 0;
    while (lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (finished_op) break;
      select_op = 2'($urandom);
      arg1      = 10'($urandom);
      arg2      = 10'($urandom);
    end
    o = out1;
    e = error;
    if (!finished_op) lat = -1;
    enable = 1'b0;
  endtask

  task automatic test_reset();
    int cyc = 0;
    int pulses = 0;
    resetn = 1'b0;
    enable = 1'b0;
    select_op = '0;
    arg1 = '0;
    arg2 = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, finished_op, error, out1} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: busy=%b fin=%b err=%b out1=%h, want 1 0 0 0000",
               busy, finished_op, error, out1);
    end
    resetn = 1'b1;
    while (busy && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      if (finished_op) pulses++;
    end
    checks++;
    if (cyc !== 53 || pulses !== 0) begin
      errors++;
      $display("FAIL auto_init: cycles=%0d pulses=%0d, want 53 and 0", cyc, pulses);
    end
    model_reset();
  endtask

  task automatic test_count();
    logic [15:0] o, eo;
    logic e, ee, ec;
    int lat, el;
    for (int id = 0; id < 3; id++) begin
      model_exec(2'd3, 10'(id), 10'd0, eo, ee, el, ec);
      run_op(2'd3, 10'(id), 10'd0, o, e, lat);
      checks++;
      if (o !== ((id == 0) ? 16'd52 : 16'd0) || e !== 1'b0 || lat !== 1) begin
        errors++;
        $display("FAIL count_list%0d: out1=%0d err=%b lat=%0d, want %0d 0 1",
                 id, o, e, lat, eo);
      end
    end
  endtask

  task automatic test_remove_wrap();
    logic [15:0] o, eo;
    logic e, ee, ec;
    int lat, el;
    model_exec(2'd1, 10'd0, 10'd0, eo, ee, el, ec);
    run_op(2'd1, 10'd0, 10'd0, o, e, lat);
    checks++;
    if (o !== 16'd1 || e !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL remove_idx0: out1=%0d err=%b lat=%0d, want 1 0 2", o, e, lat);
    end
    model_exec(2'd1, 10'd0, 10'd51, eo, ee, el, ec);
    run_op(2'd1, 10'd0, 10'd51, o, e, lat);
    checks++;
    if (o !== 16'd2 || e !== 1'b0 || lat !== 53) begin
      errors++;
      $display("FAIL remove_wrap51: out1=%0d err=%b lat=%0d, want 2 0 53", o, e, lat);
    end
    model_exec(2'd3, 10'd0, 10'd0, eo, ee, el, ec);
    run_op(2'd3, 10'd0, 10'd0, o, e, lat);
    checks++;
    if (o !== 16'd50) begin
      errors++;
      $display("FAIL deck_count_50: out1=%0d, want 50", o);
    end
  endtask

  task automatic test_push_remove_single();
    logic [15:0] o, eo;
    logic e, ee, ec;
    int lat, el;
    model_exec(2'd0, 10'd1, 10'd7, eo, ee, el, ec);
    run_op(2'd0, 10'd1, 10'd7, o, e, lat);
    checks++;
    if (e !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL push_player7: err=%b lat=%0d, want 0 2", e, lat);
    end
    model_exec(2'd1, 10'd1, 10'd5, eo, ee, el, ec);
    run_op(2'd1, 10'd1, 10'd5, o, e, lat);
    checks++;
    if (o !== 16'd7 || e !== 1'b0 || lat !== 7) begin
      errors++;
      $display("FAIL remove_single: out1=%0d err=%b lat=%0d, want 7 0 7", o, e, lat);
    end
    model_exec(2'd3, 10'd1, 10'd0, eo, ee, el, ec);
    run_op(2'd3, 10'd1, 10'd0, o, e, lat);
    checks++;
    if (o !== 16'd0) begin
      errors++;
      $display("FAIL player_empty: out1=%0d, want 0", o);
    end
    model_exec(2'd1, 10'd1, 10'd0, eo, ee, el, ec);
    run_op(2'd1, 10'd1, 10'd0, o, e, lat);
    checks++;
    if (o !== 16'hFFFF || e !== 1'b1) begin
      errors++;
      $display("FAIL remove_emptied: out1=%h err=%b, want ffff 1", o, e);
    end
  endtask

  task automatic test_errors();
    logic [1:0]  ops [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
    logic [9:0]  a1s [8] = '{10'd3, 10'd2, 10'd1, 10'd1, 10'h3FF, 10'd2, 10'd2, 10'd2};
    logic [9:0]  a2s [8] = '{10'd5, 10'd0, 10'd0, 10'd53, 10'd0, 10'd10, 10'd11, 10'd12};
    logic [15:0] o, eo;
    logic e, ee, ec;
    int lat, el;
    // Last three: two pushes use up the two free nodes, the third finds none.
    for (int k = 0; k < 8; k++) begin
      model_exec(ops[k], a1s[k], a2s[k], eo, ee, el, ec);
      run_op(ops[k], a1s[k], a2s[k], o, e, lat);
      checks++;
      if (e !== ee || lat !== el || (ec && o !== eo)) begin
        errors++;
        $display("FAIL error_case%0d: err=%b lat=%0d out1=%h, want %b %0d %h",
                 k, e, lat, o, ee, el, eo);
      end
    end
    for (int id = 0; id < 3; id++) begin
      model_exec(2'd3, 10'(id), 10'd0, eo, ee, el, ec);
      run_op(2'd3, 10'(id), 10'd0, o, e, lat);
      checks++;
      if (o !== eo) begin
        errors++;
        $display("FAIL count_after_err%0d: out1=%0d, want %0d", id, o, eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] eo;
    logic ee, ec;
    int el, cyc;
    cyc = 0;
    model_exec(2'd1, 10'd0, 10'd0, eo, ee, el, ec);
    select_op = 2'd1;
    arg1 = 10'd0;
    arg2 = 10'd0;
    enable = 1'b1;
    while (cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      if (finished_op) break;
    end
    checks++;
    if (finished_op !== 1'b1 || out1 !== eo) begin
      errors++;
      $display("FAIL hold_first: fin=%b out1=%0d, want 1 %0d", finished_op, out1, eo);
    end
    @(posedge clock); #1;
    checks++;
    if (finished_op !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_retrigger: fin=%b busy=%b, want 0 0", finished_op, busy);
    end
    model_exec(2'd3, 10'd0, 10'd0, eo, ee, el, ec);
    select_op = 2'd3;
    @(posedge clock); #1;
    checks++;
    if (finished_op !== 1'b1 || out1 !== eo) begin
      errors++;
      $display("FAIL hold_second_cmd: fin=%b out1=%0d, want 1 %0d", finished_op, out1, eo);
    end
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (finished_op !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_quiet: fin=%b busy=%b, want 0 0", finished_op, busy);
    end
  endtask

  task automatic test_init_deck();
    logic [15:0] o, eo;
    logic e, ee, ec;
    int lat, el;
    model_exec(2'd2, 10'd0, 10'd0, eo, ee, el, ec);
    run_op(2'd2, 10'd0, 10'd0, o, e, lat);
    checks++;
    if (e !== 1'b0 || lat !== 53) begin
      errors++;
      $display("FAIL init_deck: err=%b lat=%0d, want 0 53", e, lat);
    end
    for (int id = 0; id < 3; id++) begin
      model_exec(2'd3, 10'(id), 10'd0, eo, ee, el, ec);
      run_op(2'd3, 10'(id), 10'd0, o, e, lat);
      checks++;
      if (o !== eo) begin
        errors++;
        $display("FAIL init_count%0d: out1=%0d, want %0d", id, o, eo);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] o, eo;
    logic e, ee, ec;
    int lat, el, cyc;
    cyc = 0;
    select_op = 2'd1;
    arg1 = 10'd0;
    arg2 = 10'd40;
    enable = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b0;
    enable = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    checks++;
    if (busy !== 1'b1 || out1 !== 16'd0 || finished_op !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: busy=%b out1=%h fin=%b, want 1 0000 0", busy, out1, finished_op);
    end
    while (busy && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    model_reset();
    model_exec(2'd3, 10'd0, 10'd0, eo, ee, el, ec);
    run_op(2'd3, 10'd0, 10'd0, o, e, lat);
    checks++;
    if (o !== 16'd52 || lat !== 1) begin
      errors++;
      $display("FAIL midop_deck: out1=%0d lat=%0d, want 52 1", o, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] o, eo;
    logic e, ee, ec;
    int lat, el, r, id, card, pidx, sum;
    logic [1:0] op;
    logic [9:0] a1, a2;
    pool.delete();
    for (int c = 1; c <= 52; c++) begin
      bit found = 0;
      for (int l = 0; l < 3; l++)
        for (int k = 0; k < msize[l]; k++)
          if (mlist[l][k] == c) found = 1;
      if (!found) pool.push_back(c);
    end
    for (int n = 0; n < 2000; n++) begin
      r    = $urandom_range(0, 9);
      id   = ($urandom_range(0, 31) == 0) ? 3 : $urandom_range(0, 2);
      pidx = -1;
      if (r < 4) begin
        op = 2'd0;
        if (pool.size() > 0 && $urandom_range(0, 15) != 0) begin
          pidx = $urandom_range(0, pool.size() - 1);
          card = pool[pidx];
        end else if (pool.size() == 0) card = $urandom_range(1, 52);
        else card = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(53, 63);
      end else if (r < 8) begin
        op   = 2'd1;
        card = $urandom_range(0, 63);
      end else begin
        op   = 2'd3;
        card = $urandom_range(0, 63);
      end
      a1 = {8'($urandom), 2'(id)};
      a2 = {4'($urandom), 6'(card)};
      model_exec(op, a1, a2, eo, ee, el, ec);
      run_op(op, a1, a2, o, e, lat);
      checks++;
      if (e !== ee || lat !== el || (ec && o !== eo)) begin
        errors++;
        $display("FAIL random_op%0d: op=%0d id=%0d arg=%0d err=%b lat=%0d out1=%0d, want %b %0d %0d",
                 n, op, id, card, e, lat, o, ee, el, eo);
      end
      if (op == 2'd0 && !ee && pidx >= 0) pool.delete(pidx);
      if (op == 2'd1 && !e && o != 16'hFFFF) begin
        bit dup = 0;
        foreach (pool[k]) if (pool[k] == int'(o)) dup = 1;
        checks++;
        if (dup) begin
          errors++;
          $display("FAIL random_dup%0d: card %0d returned while already out", n, o);
        end
        pool.push_back(int'(o));
      end
    end
    sum = 0;
    for (int l = 0; l < 3; l++) begin
      model_exec(2'd3, 10'(l), 10'd0, eo, ee, el, ec);
      run_op(2'd3, 10'(l), 10'd0, o, e, lat);
      sum += int'(o);
    end
    checks++;
    if (sum + pool.size() !== 52) begin
      errors++;
      $display("FAIL invariant: lists=%0d out=%0d, want total 52", sum, pool.size());
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_remove_wrap();
    test_push_remove_single();
    test_errors();
    test_back_to_back();
    test_init_deck();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_list_memory.md
Name: card_list_memory

Overview:
- Responder side of the card-memory handshake (enable / select_op / arg1 / arg2 → finished_op / out1) driven by the war game controller.
- Holds up to three singly-linked card lists (deck, player hand, com hand) in a 64-node register array.
- Supports four operations: push a card, remove the card at an index, rebuild the deck, and query a list's length.
- Sits between the game FSM and storage; the game FSM never touches node pointers directly.

Parameters:
- NUM_CARDS, 52, cards in a full deck; card values are 1..NUM_CARDS.
- NODE_AW, 6, node address width; node 6'h3F is reserved as NULL.

Ports:
- clock  in  1  system clock
- resetn  in  1  reset: synchronous, active-low; clock: clock
- enable  in  1  command request; held high by the initiator until it sees finished_op
- select_op  in  2  0=PUSH, 1=REMOVE_AT, 2=INIT_DECK, 3=COUNT
- arg1  in  10  list id in arg1[1:0]: 0=deck, 1=player, 2=com; 3 is invalid; arg1[9:2] ignored
- arg2  in  10  PUSH: card in arg2[5:0]; REMOVE_AT: index in arg2[5:0]; otherwise ignored
- finished_op  out  1  one-cycle done pulse
- out1  out  16  result: {10'd0, card} for REMOVE_AT, {10'd0, count} for COUNT; holds its value until the next result
- busy  out  1  high whenever state is not IDLE
- error  out  1  one-cycle pulse, coincident with finished_op, on an illegal command

Behaviour:
- Storage:
  - node_card[64] and node_next[64], each 6 bits.
  - head[3] and count[3] (6 bits each); free_head (6 bits).
  - NULL = 6'h3F.
- Reset (resetn low at a clock edge):
  - finished_op=0, error=0, out1=0.
  - All heads and free_head = NULL; all counts = 0.
  - State = INIT, so busy=1 in the first cycle after reset; the deck rebuild runs automatically.
- States: IDLE, INIT, PUSH, SEEK, UNLINK, DONE.
- IDLE:
  - If enable=1, latch select_op, arg1 and arg2.
  - Dispatch on the latched op:
    - PUSH → PUSH.
    - REMOVE_AT → SEEK (cur=head, prev=NULL, steps=arg2[5:0]).
    - INIT_DECK → INIT (i=0).
    - COUNT → DONE with out1=count[id].
  - Illegal commands go straight to DONE with error asserted:
    - list id 3;
    - PUSH with free_head=NULL;
    - PUSH with card 0 or card > NUM_CARDS;
    - REMOVE_AT on an empty list.
  - On error: out1=16'hFFFF and no list state changes.
- INIT:
  - Each cycle i: node i gets card i+1 and next=i+1; node NUM_CARDS-1 gets next=NULL.
  - Runs NUM_CARDS cycles.
  - On completion: head[0]=0, count[0]=NUM_CARDS, player and com emptied, free_head=NULL.
  - Then → DONE. After the automatic post-reset INIT, DONE does not pulse finished_op.
- PUSH (1 cycle):
  - n=free_head; free_head=node_next[n].
  - node_card[n]=card; node_next[n]=head[id]; head[id]=n; count[id]+1.
  - Then → DONE.
- SEEK (one cycle per step):
  - While steps≠0: prev=cur; cur=node_next[cur]; steps-1.
  - If node_next[cur]=NULL, wrap: cur=head[id], prev=NULL.
  - Net effect: removes 0-based position arg2[5:0] mod count.
  - When steps=0 → UNLINK.
- UNLINK (1 cycle):
  - out1={10'd0,node_card[cur]}.
  - If prev=NULL: head[id]=node_next[cur]; else node_next[prev]=node_next[cur].
  - node_next[cur]=free_head; free_head=cur; count[id]-1.
  - Then → DONE.
- DONE: finished_op=1 for exactly this cycle; → IDLE unconditionally.
  - enable is not sampled in DONE, so an initiator still holding enable does not retrigger.
  - A new command is accepted in the following IDLE cycle.
- Latency from the IDLE capture edge to finished_op high:
  - COUNT: 1 cycle.
  - PUSH: 2 cycles.
  - REMOVE_AT: steps+2 cycles.
  - INIT_DECK: NUM_CARDS+1 cycles.
- Boundary cases:
  - REMOVE_AT on a single-card list with any index removes that card and sets head=NULL.
  - select_op and args changing while busy are ignored.
  - Reset mid-operation aborts the operation and restarts INIT.
- Invariant: count[0]+count[1]+count[2]+free-list length = NUM_CARDS after any completed operation.

Decomposition:
- Package card_mem_pkg holds:
  - op codes OP_PUSH/OP_REMOVE/OP_INIT/OP_COUNT;
  - list ids LIST_DECK/LIST_PLAYER/LIST_COM;
  - the NULL_NODE constant;
  - the state enum.
- One sub-module, card_node_array: the 64-entry card/next register file.
  - Two combinational read ports, one write port for card and one for next.
  - Keeps the FSM free of array indexing detail.

Test Plan:
- Reset, wait for busy=0, COUNT deck → finished_op pulse, out1=52; COUNT player → out1=0.
- REMOVE_AT deck idx 0, then idx 51 on the remaining 51 cards (wraps to position 0) → out1=1, then out1=2; deck count=50.
- PUSH card 7 to player, then REMOVE_AT player idx 5 → out1=7, player count back to 0, head=NULL.
- PUSH with list id 3, and REMOVE_AT on an empty com list → error and finished_op in the same cycle, out1=16'hFFFF, counts unchanged.
- Hold enable high across DONE → exactly one operation executes per command; a second command is accepted only after IDLE.
- Random 2000-op mix of PUSH/REMOVE_AT/COUNT against a queue model → every removed card matches, the count invariant sums to 52, and no duplicate card is ever returned.
